sp_ram_bist: RTL
================

# sp_ram_bist

March C- built-in self-test initiator for the single-port data/instruction SRAM. It drives the SRAM request port (enable, byte address, write data, write enable, byte enables) and checks read data returned one cycle later. It sits between the SoC control registers (start/abort/status) and the `sp_ram` port, muxed in ahead of the core during test.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 15: byte-address width of the SRAM port.
- `DATA_WIDTH`, default 32: data width, a multiple of 8.
- `NUM_WORDS`, default 8192: words under test. Must satisfy NUM_WORDS·(DATA_WIDTH/8) ≤ 2^ADDR_WIDTH.

**Ports**
- `clk`, in, 1: clock. One clock domain.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `start_i`, in, 1: start pulse. Accepted only when not busy.
- `abort_i`, in, 1: synchronous abort.
- `busy_o`, out, 1: test in progress.
- `done_o`, out, 1: test completed. Held until the next accepted start or reset.
- `fail_o`, out, 1: sticky; equals (err_cnt_o != 0).
- `err_cnt_o`, out, 16: mismatch count, saturating at 0xFFFF.
- `fail_addr_o`, out, ADDR_WIDTH: byte address of the first mismatch.
- `fail_exp_o`, out, DATA_WIDTH: expected data at the first mismatch.
- `fail_rdata_o`, out, DATA_WIDTH: read data at the first mismatch.
- `mem_en_o`, out, 1: SRAM request enable.
- `mem_addr_o`, out, ADDR_WIDTH: SRAM byte address, word aligned.
- `mem_wdata_o`, out, DATA_WIDTH: SRAM write data.
- `mem_we_o`, out, 1: SRAM write enable.
- `mem_be_o`, out, DATA_WIDTH/8: byte enables. Always all ones while `mem_en_o` = 1.
- `mem_rdata_i`, in, DATA_WIDTH: SRAM read data. Valid the cycle after a read request.

## Operation

**Backgrounds**
- D0 = all zeros.
- D1 = all ones.

**Addressing**
- `mem_addr_o` = word index << log2(DATA_WIDTH/8), zero-extended to ADDR_WIDTH.

**States**
- IDLE
- M0: ascending; write D0.
- M1: ascending; read D0, then write D1.
- M2: ascending; read D1, then write D0.
- M3: descending; read D0, then write D1.
- M4: descending; read D1, then write D0.
- M5: ascending; read D0.
- DRAIN
- DONE

**Access pattern**
- Read+write elements (M1–M4) spend 2 cycles per word: a read cycle, then a write cycle to the same address.
- Write-only (M0) and read-only (M5) elements spend 1 cycle per word.
- Index counter runs 0→N−1 when ascending and N−1→0 when descending.
- On the last word of an element, the FSM moves to the next element with no idle cycle.

**Compare**
- In the cycle after each read request, `mem_rdata_i` is compared with a registered copy of the expected value and address.
- On mismatch:
  - `err_cnt_o` increments, saturating.
  - `fail_o` is set.
  - If this is the first error, the fail_* outputs are captured.
- DRAIN is one cycle with `mem_en_o` = 0 that compares the final M5 read.

**Control**
- `start_i` in IDLE or DONE:
  - clears `err_cnt_o`, `fail_o`, fail_* and `done_o`;
  - enters M0 at index 0.
- `start_i` while busy is ignored.
- `abort_i` while busy:
  - goes to IDLE at the next edge;
  - no pending compare is recorded;
  - `done_o` stays 0;
  - error status is retained.
- `abort_i` has priority over `start_i` in the same cycle.
- `abort_i` in IDLE or DONE has no effect.

**Reset**
- All outputs are 0, except `mem_be_o`, which is 0 while idle.
- FSM is in IDLE.
- Reset mid-test stops traffic immediately: `mem_en_o` = 0 asynchronously.

## Timing

- The request outputs are driven from registered state and index. They are not combinational from any input.
- `start_i` is sampled at edge k. `busy_o` = 1 and the first M0 request appear after edge k.
- Request cycles:
  - exactly 10·NUM_WORDS consecutive cycles with `mem_en_o` = 1;
  - then 1 DRAIN cycle;
  - then DONE, where `busy_o` = 0 and `done_o` = 1.
- Totals per run:
  - `busy_o` is high for 10·NUM_WORDS + 1 cycles;
  - 5·NUM_WORDS reads and 5·NUM_WORDS writes.
- Mismatch updates: `err_cnt_o`, `fail_o` and fail_* change at the edge ending the compare cycle, one cycle after the read request.
- Bank boundaries, where the SRAM row select changes between consecutive accesses, need no bubbles. The SRAM pipelines its row select with the data.

## Configuration

- Macro `SP_RAM_BIST_ERR_LOG_EN`.
- Defined: first-failure capture registers are implemented and drive `fail_addr_o`, `fail_exp_o` and `fail_rdata_o`.
- Undefined:
  - those three outputs are tied to 0 and no capture registers exist;
  - `err_cnt_o` and `fail_o` are unchanged.

## Test plan

1. **Clean model**, NUM_WORDS = 16, start pulse:
   - `busy_o` high for exactly 161 cycles;
   - 80 writes and 80 reads;
   - then `done_o` = 1, `fail_o` = 0, `err_cnt_o` = 0.
2. **Stuck-at-0 on bit 5 of word 3** (32-bit data):
   - `err_cnt_o` = 2 (M2 and M4 reads);
   - `fail_o` = 1;
   - with the macro: `fail_addr_o` = 0x0C, `fail_exp_o` = 0xFFFFFFFF, `fail_rdata_o` = 0xFFFFFFDF.
3. **Address order**:
   - M3 requests go 0x3C, 0x3C, 0x38, 0x38 … 0x00, in read/write pairs;
   - M0 requests go 0x00 … 0x3C, with `mem_we_o` = 1 and `mem_be_o` = 0xF.
4. **Abort during M2**:
   - `mem_en_o` = 0 and `busy_o` = 0 in the next cycle;
   - `done_o` = 0;
   - a following start completes a clean 161-cycle run.
5. **Reset asserted mid-M1**:
   - all outputs are 0 immediately;
   - after release the block is in IDLE and a start gives a normal run.
6. **start_i pulsed while busy**: the run length is unchanged.
   **start_i pulsed in DONE after test 2**: `err_cnt_o` = 0 and `done_o` = 0 one cycle later, and a new run begins.

Source files
------------

// File: rtl/sp_ram_bist.sv
// March C- self-test initiator for the single-port SRAM request port.
// Define SP_RAM_BIST_ERR_LOG_EN to build the first-failure capture registers.
module sp_ram_bist #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8192
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [15:0]             err_cnt_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [DATA_WIDTH-1:0]   fail_exp_o,
  output logic [DATA_WIDTH-1:0]   fail_rdata_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int SH = $clog2(BW);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] D0 = '0;
  localparam logic [DATA_WIDTH-1:0] D1 = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    wr_ph;
  logic                    cmp_vld;
  logic [DATA_WIDTH-1:0]   cmp_exp;
  logic [15:0]             err_cnt;

  logic                    rd_req;
  logic                    wr_req;
  logic [DATA_WIDTH-1:0]   bg_rd;
  logic [DATA_WIDTH-1:0]   bg_wr;
  logic                    busy;
  logic                    stop;
  logic                    start_acc;
  logic                    mism;
  logic                    paired;
  logic                    desc;
  logic                    nxt_desc;
  logic                    last;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign stop      = busy && abort_i;
  assign start_acc = !busy && start_i;
  assign mism      = cmp_vld && (mem_rdata_i != cmp_exp);

  assign paired   = (state == S_M1) || (state == S_M2) ||
                    (state == S_M3) || (state == S_M4);
  assign desc     = (state == S_M3) || (state == S_M4);
  assign nxt_desc = (state == S_M2) || (state == S_M3);
  assign last     = desc ? (idx == '0) : (idx == LAST);

  always_comb begin
    rd_req = 1'b0;
    wr_req = 1'b0;
    bg_rd  = D0;
    bg_wr  = D0;
    unique case (state)
      S_M0: wr_req = 1'b1;
      S_M1: begin
        bg_wr  = D1;
        rd_req = !wr_ph;
        wr_req = wr_ph;
      end
      S_M2: begin
        bg_rd  = D1;
        rd_req = !wr_ph;
        wr_req = wr_ph;
      end
      S_M3: begin
        bg_wr  = D1;
        rd_req = !wr_ph;
        wr_req = wr_ph;
      end
      S_M4: begin
        bg_rd  = D1;
        rd_req = !wr_ph;
        wr_req = wr_ph;
      end
      S_M5: rd_req = 1'b1;
      default: ;
    endcase
  end

  assign mem_en_o    = rd_req | wr_req;
  assign mem_we_o    = wr_req;
  assign mem_wdata_o = bg_wr;
  assign mem_addr_o  = idx << SH;
  assign mem_be_o    = {BW{mem_en_o}};

  assign busy_o    = busy;
  assign done_o    = (state == S_DONE);
  assign err_cnt_o = err_cnt;
  assign fail_o    = (err_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      wr_ph   <= 1'b0;
      cmp_vld <= 1'b0;
      cmp_exp <= '0;
      err_cnt <= '0;
    end else if (stop) begin
      state   <= S_IDLE;
      wr_ph   <= 1'b0;
      cmp_vld <= 1'b0;
    end else begin
      cmp_vld <= rd_req;
      cmp_exp <= bg_rd;
      if (mism && (err_cnt != '1))
        err_cnt <= err_cnt + 16'd1;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state   <= S_M0;
            idx     <= '0;
            wr_ph   <= 1'b0;
            err_cnt <= '0;
          end
        end
        S_DRAIN: state <= S_DONE;
        default: begin
          if (paired && !wr_ph) begin
            wr_ph <= 1'b1;
          end else begin
            wr_ph <= 1'b0;
            if (last) begin
              state <= state_t'(state + 4'd1);
              idx   <= nxt_desc ? LAST : '0;
            end else begin
              idx <= desc ? idx - 1'b1 : idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef SP_RAM_BIST_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_exp;
  logic [DATA_WIDTH-1:0] f_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_addr <= '0;
      f_addr   <= '0;
      f_exp    <= '0;
      f_rdata  <= '0;
    end else if (start_acc) begin
      f_addr  <= '0;
      f_exp   <= '0;
      f_rdata <= '0;
    end else if (!stop) begin
      cmp_addr <= mem_addr_o;
      if (mism && (err_cnt == '0)) begin
        f_addr  <= cmp_addr;
        f_exp   <= cmp_exp;
        f_rdata <= mem_rdata_i;
      end
    end
  end

  assign fail_addr_o  = f_addr;
  assign fail_exp_o   = f_exp;
  assign fail_rdata_o = f_rdata;
`else
  assign fail_addr_o  = '0;
  assign fail_exp_o   = '0;
  assign fail_rdata_o = '0;
`endif

endmodule
